// File: rtl/nibble_word_packer_if.sv
// Byte-in / word-out stream bundle for the nibble word packer.
interface nibble_word_packer_if #(
    parameter int BYTES = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic [7:0]                   in_data;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic [BYTES*8-1:0]           out_data;
    logic [$clog2(BYTES+1)-1:0]   out_bytes;
    logic [15:0]                  word_cnt;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_bytes, word_cnt
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_bytes, word_cnt
    );
endinterface

// File: rtl/nibble_word_packer.sv
// Packs a byte stream into BYTES-wide words, MSB lane first, optionally undoing the
// upstream nibble swap; finished words queue in a DEPTH-entry FIFO.
module nibble_word_packer #(
    parameter int BYTES        = 4,
    parameter int DEPTH        = 2,
    parameter bit SWAP_NIBBLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_word_packer_if.slave  bus
);
    localparam int LW = $clog2(BYTES);
    localparam int BW = $clog2(BYTES+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH+1);
    localparam int WW = BYTES*8;

    logic [LW-1:0] lane_q, lane_d;
    logic [WW-1:0] acc_q, acc_d;
    logic [WW-1:0] mem_q [DEPTH];
    logic [WW-1:0] mem_d [DEPTH];
    logic [BW-1:0] nb_q [DEPTH];
    logic [BW-1:0] nb_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          in_ready, accept, close, pop;
    logic [7:0]    byte_in;
    logic [WW-1:0] word;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness depends only on occupancy so a closing byte always finds a free slot.
    assign in_ready = (occ_q != OW'(DEPTH));

    always_comb begin
        byte_in  = SWAP_NIBBLES ? {bus.in_data[3:0], bus.in_data[7:4]} : bus.in_data;
        accept   = bus.in_valid && in_ready;
        close    = accept && (bus.in_last || lane_q == LW'(BYTES-1));
        pop      = (occ_q != '0) && bus.out_ready;
        word     = acc_q;
        word[(BYTES-1-int'(lane_q))*8 +: 8] = byte_in;

        lane_d   = lane_q;
        acc_d    = acc_q;
        mem_d    = mem_q;
        nb_d     = nb_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (accept) begin
            if (close) begin
                lane_d           = '0;
                acc_d            = '0;
                mem_d[wr_ptr_q]  = word;
                nb_d[wr_ptr_q]   = BW'(lane_q) + BW'(1);
                wr_ptr_d         = nxt(wr_ptr_q);
                cnt_d            = cnt_q + 16'd1;
            end else begin
                lane_d = lane_q + 1'b1;
                acc_d  = word;
            end
        end
        if (pop) rd_ptr_d = nxt(rd_ptr_q);
        occ_d = occ_q + OW'(close) - OW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q   <= '0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                nb_q[i]  <= '0;
            end
        end else begin
            lane_q   <= lane_d;
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
            nb_q     <= nb_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (occ_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.out_bytes = nb_q[rd_ptr_q];
    assign bus.word_cnt  = cnt_q;
endmodule

// File: tb/tb_nibble_word_packer.sv
// Randomized and directed bench for nibble_word_packer: two instances (swap on/off)
// share one input stream and are scored against a queue-based word model.
module tb_nibble_word_packer;
    localparam int BYTES = 4;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  n;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    bit         done;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  cur[$];
    ent_t        exp_s[$];
    ent_t        exp_n[$];
    logic [15:0] m_cnt = 16'h0;

    nibble_word_packer_if #(.BYTES(BYTES)) if_s ();
    nibble_word_packer_if #(.BYTES(BYTES)) if_n ();

    assign if_s.in_valid = in_valid;  assign if_n.in_valid = in_valid;
    assign if_s.in_data  = in_data;   assign if_n.in_data  = in_data;
    assign if_s.in_last  = in_last;   assign if_n.in_last  = in_last;
    assign if_s.out_ready = out_ready; assign if_n.out_ready = out_ready;

    nibble_word_packer #(.BYTES(BYTES), .DEPTH(DEPTH), .SWAP_NIBBLES(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(if_s));
    nibble_word_packer #(.BYTES(BYTES), .DEPTH(DEPTH), .SWAP_NIBBLES(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .bus(if_n));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: collect raw bytes, emit a word when the spec's close rule fires.
    always @(negedge clk or negedge rst_n) begin : model
        int occ;
        bit acc, pp;
        logic [31:0] ws, wn;
        logic [7:0]  b;
        if (!rst_n) begin
            cur.delete(); exp_s.delete(); exp_n.delete(); m_cnt = 16'h0;
        end else begin
            occ = exp_s.size();
            chk("in_ready_s", {31'b0, if_s.in_ready}, {31'b0, occ != DEPTH});
            chk("in_ready_n", {31'b0, if_n.in_ready}, {31'b0, occ != DEPTH});
            chk("out_valid_s", {31'b0, if_s.out_valid}, {31'b0, occ != 0});
            chk("out_valid_n", {31'b0, if_n.out_valid}, {31'b0, occ != 0});
            chk("word_cnt", {16'b0, if_s.word_cnt}, {16'b0, m_cnt});
            if (occ != 0) begin
                chk("head_data_s", if_s.out_data, exp_s[0].d);
                chk("head_data_n", if_n.out_data, exp_n[0].d);
                chk("head_bytes_s", {29'b0, if_s.out_bytes}, {29'b0, exp_s[0].n});
            end
            acc = in_valid && (occ != DEPTH);
            pp  = (occ != 0) && out_ready;
            if (pp) begin
                void'(exp_s.pop_front());
                void'(exp_n.pop_front());
            end
            if (acc) begin
                cur.push_back(in_data);
                if (in_last || cur.size() == BYTES) begin
                    ws = '0; wn = '0;
                    for (int i = 0; i < cur.size(); i++) begin
                        b = cur[i];
                        wn[31-8*i -: 8] = b;
                        ws[31-8*i -: 8] = {b[3:0], b[7:4]};
                    end
                    exp_s.push_back('{d: ws, n: 3'(cur.size())});
                    exp_n.push_back('{d: wn, n: 3'(cur.size())});
                    cur.delete();
                    m_cnt = m_cnt + 16'd1;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the byte was taken.
    task automatic send(input logic [7:0] b, input logic last);
        bit got = 0;
        in_valid = 1'b1; in_data = b; in_last = last;
        for (int t = 0; t < 500 && !got; t++) begin
            @(negedge clk);
            got = if_s.in_ready;
            @(posedge clk); #1;
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        idle(0);
        out_ready = 1'b1;
        for (int t = 0; t < 50 && exp_s.size() != 0; t++) begin
            @(posedge clk); #2;
        end
        chk("drain", exp_s.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid_s", {31'b0, if_s.out_valid}, 32'd0);
        chk("rst_out_valid_n", {31'b0, if_n.out_valid}, 32'd0);
        chk("rst_word_cnt", {16'b0, if_s.word_cnt}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        chk("rst_out_data", if_s.out_data, 32'd0);
        chk("rst_out_bytes", {29'b0, if_s.out_bytes}, 32'd0);
        chk("rst_valid", {31'b0, if_s.out_valid}, 32'd0);
        chk("rst_cnt", {16'b0, if_s.word_cnt}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic 4-byte word
        send(8'h5A, 0); send(8'hA5, 0); send(8'h3C, 0); send(8'hC3, 0); idle(0);
        @(negedge clk);
        chk("t1_data_s", if_s.out_data, 32'hA55AC33C);
        chk("t1_data_n", if_n.out_data, 32'h5AA53CC3);
        chk("t1_bytes", {29'b0, if_s.out_bytes}, 32'd4);
        chk("t1_cnt", {16'b0, if_s.word_cnt}, 32'd1);
        @(posedge clk); #1;

        // partial flush, then a fresh word
        send(8'h12, 0); send(8'h34, 1); idle(0);
        @(negedge clk);
        chk("t2_data_s", if_s.out_data, 32'h21430000);
        chk("t2_bytes", {29'b0, if_s.out_bytes}, 32'd2);
        @(posedge clk); #1;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); idle(0);
        @(negedge clk);
        chk("t2b_data_s", if_s.out_data, 32'h10203040);
        chk("t2b_bytes", {29'b0, if_s.out_bytes}, 32'd4);
        @(posedge clk); #1;
        drain();

        // backpressure: buffer fills, byte 08 waits
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 12; i++) send(8'(i), 0);
            begin
                repeat (12) @(negedge clk);
                chk("t3_in_ready", {31'b0, if_n.in_ready}, 32'd0);
                chk("t3_head_n", if_n.out_data, 32'h00010203);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        idle(0);
        @(negedge clk);
        chk("t3_last_n", if_n.out_data, 32'h08090A0B);
        @(posedge clk); #1;
        drain();

        // out_ready toggling every cycle
        done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) send(8'($urandom), $urandom_range(7) == 0);
                done = 1;
            end
            while (!done) begin @(posedge clk); #1 out_ready = ~out_ready; end
        join
        drain();

        // random gaps, random flushes, random backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
                    send(8'($urandom), $urandom_range(7) == 0);
                end
                done = 1;
            end
            while (!done) begin @(posedge clk); #1 out_ready = 1'($urandom_range(1)); end
        join
        drain();

        // reset with a buffered word and a half-built word
        out_ready = 1'b0;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        send(8'h55, 0); send(8'h66, 0); idle(0);
        pulse_reset();
        out_ready = 1'b1;
        send(8'h1E, 0); send(8'h2D, 0); send(8'h3C, 0); send(8'h4B, 0); idle(0);
        @(negedge clk);
        chk("t5_data_n", if_n.out_data, 32'h1E2D3C4B);
        chk("t5_data_s", if_s.out_data, 32'hE1D2C3B4);
        chk("t5_cnt", {16'b0, if_s.word_cnt}, 32'd1);
        @(posedge clk); #1;
        drain();

        // word counter wrap
        pulse_reset();
        for (int i = 0; i < 65535; i++) send(8'(i), 1);
        idle(0);
        @(negedge clk);
        chk("t6_cnt_ffff", {16'b0, if_s.word_cnt}, 32'h0000FFFF);
        @(posedge clk); #1;
        send(8'h77, 1); idle(0);
        @(negedge clk);
        chk("t6_cnt_wrap", {16'b0, if_s.word_cnt}, 32'h00000000);
        chk("t6_bytes", {29'b0, if_s.out_bytes}, 32'd1);
        @(posedge clk); #1;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
